// File: rtl/cmv300_sensor_emu.sv
// CMV300 sensor emulator: answers FRAME_REQ rising edges with an FVAL/LVAL/DVAL-framed
// test-pattern frame after a SYS_RES_N holdoff.
module cmv300_sensor_emu #(
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned H_BLANK    = 16,
  parameter int unsigned FOT_CYCLES = 32,
  parameter int unsigned HOLDOFF    = 80
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sys_res_n,
  input  logic        i_frame_req,
  input  logic [1:0]  i_pattern,
  output logic        o_fval,
  output logic        o_lval,
  output logic        o_dval,
  output logic [9:0]  o_data,
  output logic        o_ready,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FOT, S_LINE, S_HBLANK} state_t;

  localparam logic [15:0] X_LAST    = 16'(H_PIXELS - 1);
  localparam logic [15:0] Y_LAST    = 16'(V_LINES - 1);
  localparam logic [31:0] FOT_LAST  = 32'(FOT_CYCLES - 1);
  localparam logic [31:0] HB_LAST   = 32'(H_BLANK - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF - 1);

  state_t      state;
  logic [31:0] hold_cnt;
  logic [31:0] phase_cnt;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] x_inc;
  logic [15:0] y_inc;
  logic [1:0]  pattern;
  logic        req_prev;
  logic        req_edge;
  logic        pending;

  assign req_edge = i_frame_req & ~req_prev;

  always_comb begin
    x_inc = x + 16'd1;
    y_inc = y + 16'd1;
  end

  function automatic logic [9:0] pixel(input logic [1:0] p, input logic [9:0] px,
                                       input logic [9:0] py, input logic [9:0] fc);
    case (p)
      2'd0:    return px;
      2'd1:    return px + py;
      2'd2:    return px + fc;
      default: return 10'h2AA;
    endcase
  endfunction

  // x tracks the pixel currently on o_data, so each beat presents pixel(x+1).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_INIT;
      hold_cnt     <= '0;
      phase_cnt    <= '0;
      x            <= '0;
      y            <= '0;
      pattern      <= '0;
      req_prev     <= 1'b1;
      pending      <= 1'b0;
      o_fval       <= 1'b0;
      o_lval       <= 1'b0;
      o_dval       <= 1'b0;
      o_data       <= '0;
      o_ready      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      req_prev     <= i_frame_req;
      o_frame_done <= 1'b0;
      if (!i_sys_res_n) begin
        state    <= S_INIT;
        hold_cnt <= '0;
        pending  <= 1'b0;
        x        <= '0;
        y        <= '0;
        o_fval   <= 1'b0;
        o_lval   <= 1'b0;
        o_dval   <= 1'b0;
        o_data   <= '0;
        o_ready  <= 1'b0;
      end else begin
        case (state)
          S_INIT: begin
            if (hold_cnt == HOLD_LAST) begin
              state   <= S_IDLE;
              o_ready <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 32'd1;
            end
          end
          S_IDLE: begin
            if (req_edge) begin
              pattern   <= i_pattern;
              x         <= '0;
              y         <= '0;
              phase_cnt <= '0;
              state     <= S_FOT;
              o_ready   <= 1'b0;
            end
          end
          S_FOT: begin
            if (req_edge) pending <= 1'b1;
            if (phase_cnt == FOT_LAST) begin
              state  <= S_LINE;
              x      <= '0;
              o_fval <= 1'b1;
              o_lval <= 1'b1;
              o_dval <= 1'b1;
              o_data <= pixel(pattern, 10'd0, y[9:0], o_frame_cnt[9:0]);
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end
          S_LINE: begin
            if (req_edge) pending <= 1'b1;
            if (x == X_LAST) begin
              state     <= S_HBLANK;
              x         <= '0;
              phase_cnt <= '0;
              o_lval    <= 1'b0;
              o_dval    <= 1'b0;
              o_data    <= '0;
            end else begin
              x      <= x_inc;
              o_data <= pixel(pattern, x_inc[9:0], y[9:0], o_frame_cnt[9:0]);
            end
          end
          S_HBLANK: begin
            if (req_edge) pending <= 1'b1;
            if (phase_cnt != HB_LAST) begin
              phase_cnt <= phase_cnt + 32'd1;
            end else if (y == Y_LAST) begin
              y            <= '0;
              o_fval       <= 1'b0;
              o_frame_done <= 1'b1;
              o_frame_cnt  <= o_frame_cnt + 16'd1;
              // An edge landing on the frame-end cycle is merged into the pending request.
              if (pending || req_edge) begin
                pending   <= 1'b0;
                pattern   <= i_pattern;
                phase_cnt <= '0;
                state     <= S_FOT;
              end else begin
                state   <= S_IDLE;
                o_ready <= 1'b1;
              end
            end else begin
              y      <= y_inc;
              state  <= S_LINE;
              o_lval <= 1'b1;
              o_dval <= 1'b1;
              o_data <= pixel(pattern, 10'd0, y_inc[9:0], o_frame_cnt[9:0]);
            end
          end
          default: state <= S_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmv300_sensor_emu.sv
// Directed bench for cmv300_sensor_emu with an 8x4 frame, 3-cycle blanking,
// 5-cycle FOT and 16-cycle holdoff; outputs are sampled on the falling edge.
module tb_cmv300_sensor_emu;

  localparam int EXP_LVAL_DELAY = 5;   // edges after the request-sampling edge
  localparam int EXP_FVAL_LEN   = 44;  // 4 * (8 + 3)
  localparam int EXP_BEATS      = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        sys_res_n;
  logic        frame_req;
  logic [1:0]  pattern;
  logic        fval, lval, dval, ready, frame_done;
  logic [9:0]  data;
  logic [15:0] frame_cnt;

  int compared   = 0;
  int mismatched = 0;

  cmv300_sensor_emu #(
    .H_PIXELS  (8),
    .V_LINES   (4),
    .H_BLANK   (3),
    .FOT_CYCLES(5),
    .HOLDOFF   (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sys_res_n (sys_res_n),
    .i_frame_req (frame_req),
    .i_pattern   (pattern),
    .o_fval      (fval),
    .o_lval      (lval),
    .o_dval      (dval),
    .o_data      (data),
    .o_ready     (ready),
    .o_frame_done(frame_done),
    .o_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pat;
    int          hold;      // cycles the request level stays high
    logic [9:0]  first;     // line 0, pixel 0
    logic [9:0]  l3_first;  // line 3, pixel 0
    logic [9:0]  l3_last;   // line 3, pixel 7
    logic [15:0] cnt_after;
  } frame_t;

  frame_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [9:0] exp_pix(input logic [1:0] p, input int px, input int py,
                                         input logic [15:0] fc);
    logic [9:0] xv;
    logic [9:0] yv;
    xv = 10'(px);
    yv = 10'(py);
    case (p)
      2'd0:    return xv;
      2'd1:    return xv + yv;
      2'd2:    return xv + fc[9:0];
      default: return 10'h2AA;
    endcase
  endfunction

  task automatic run_frame(input frame_t r);
    int          lval_first = -1;
    int          fval_first = -1;
    int          fval_n = 0;
    int          beats = 0;
    int          dones = 0;
    int          bad = 0;
    int          rule_errs = 0;
    logic [9:0]  first_d = '0;
    logic [9:0]  l3f = '0;
    logic [9:0]  l3l = '0;
    logic        ready_at_done = 1'b0;
    logic [15:0] cnt_at_done = '0;
    logic [15:0] fc;
    logic [9:0]  e;
    fc = r.cnt_after - 16'd1;
    pattern   = r.pat;
    frame_req = 1'b1;
    for (int s = 0; s < 120; s++) begin
      step();
      if (s + 1 >= r.hold) frame_req = 1'b0;
      if (s == 0) check("ready_drop", ready, 0);
      if (fval) begin
        fval_n++;
        if (fval_first < 0) fval_first = s;
      end
      if (lval && lval_first < 0) lval_first = s;
      if (dval !== lval) rule_errs++;
      if (!dval && data !== 10'd0) rule_errs++;
      if (dval) begin
        e = exp_pix(r.pat, beats % 8, beats / 8, fc);
        if (data !== e && bad == 0)
          $display("FAIL pixel beat %0d: got 0x%0h expected 0x%0h", beats, data, e);
        if (data !== e) bad++;
        if (beats == 0)  first_d = data;
        if (beats == 24) l3f = data;
        if (beats == 31) l3l = data;
        beats++;
      end
      if (frame_done) begin
        dones++;
        ready_at_done = ready;
        cnt_at_done   = frame_cnt;
      end
    end
    check("lval_delay", 32'(lval_first), 32'(EXP_LVAL_DELAY));
    check("fval_start", 32'(fval_first), 32'(lval_first));
    check("fval_len", 32'(fval_n), 32'(EXP_FVAL_LEN));
    check("beats", 32'(beats), 32'(EXP_BEATS));
    check("first_pix", first_d, r.first);
    check("line3_first", l3f, r.l3_first);
    check("line3_last", l3l, r.l3_last);
    check("pixel_errs", 32'(bad), 0);
    check("dval_rules", 32'(rule_errs), 0);
    check("done_pulses", 32'(dones), 1);
    check("ready_at_done", ready_at_done, 1);
    check("cnt_at_done", cnt_at_done, r.cnt_after);
    check("cnt_final", frame_cnt, r.cnt_after);
  endtask

  initial begin
    int     last_fval;
    int     lval2;
    int     dones;
    logic   ready_first_done;
    logic [9:0] data2;
    frame_t wrap_rec;

    tbl[0] = '{2'd2, 1,   10'd0,   10'd0,   10'd7,   16'd1};
    tbl[1] = '{2'd2, 1,   10'd1,   10'd1,   10'd8,   16'd2};
    tbl[2] = '{2'd2, 1,   10'd2,   10'd2,   10'd9,   16'd3};
    tbl[3] = '{2'd1, 100, 10'd0,   10'd3,   10'd10,  16'd4};
    tbl[4] = '{2'd3, 1,   10'h2AA, 10'h2AA, 10'h2AA, 16'd5};
    tbl[5] = '{2'd0, 1,   10'd0,   10'd0,   10'd7,   16'd6};

    rst = 1'b1; sys_res_n = 1'b0; frame_req = 1'b0; pattern = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    check("rst_ready", ready, 0);
    check("rst_fval", fval, 0);
    check("rst_lval", lval, 0);
    check("rst_data", data, 0);
    check("rst_cnt", frame_cnt, 0);

    // Holdoff: 16 sampled cycles of SYS_RES_N high, with a request pulse inside it.
    rst = 1'b0; sys_res_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 4) frame_req = 1'b1;
      if (k == 5) frame_req = 1'b0;
      if (k == 15) check("holdoff_ready_15", ready, 0);
      if (k == 16) check("holdoff_ready_16", ready, 1);
    end
    for (int i = 0; i < 10; i++) step();
    check("holdoff_req_dropped_fval", fval, 0);
    check("holdoff_req_dropped_ready", ready, 1);

    foreach (tbl[i]) run_frame(tbl[i]);

    // Back-to-back: three edges mid-frame merge into one pending frame; pattern sampled at frame end.
    last_fval = -1; lval2 = -1; dones = 0; ready_first_done = 1'b1; data2 = '0;
    pattern = 2'd0; frame_req = 1'b1;
    for (int s = 0; s < 160; s++) begin
      step();
      frame_req = (s + 1 == 10) || (s + 1 == 13) || (s + 1 == 16);
      if (s == 19) pattern = 2'd3;
      if (fval && dones == 0) last_fval = s;
      if (dones == 1 && lval && lval2 < 0) begin
        lval2 = s;
        data2 = data;
      end
      if (frame_done) begin
        if (dones == 0) ready_first_done = ready;
        dones++;
      end
    end
    check("pend_dones", 32'(dones), 2);
    check("pend_ready_at_done", ready_first_done, 0);
    check("pend_gap", 32'(lval2 - last_fval), 6);
    check("pend_pattern", data2, 10'h2AA);
    check("pend_cnt", frame_cnt, 16'd8);
    check("pend_idle", ready, 1);

    // Abort during line 2 (lval steps 27..34): outputs clear, no count, holdoff reruns.
    dones = 0;
    pattern = 2'd1; frame_req = 1'b1;
    for (int s = 0; s < 60; s++) begin
      step();
      frame_req = 1'b0;
      if (frame_done) dones++;
      if (s == 29) begin
        check("abort_pre_lval", lval, 1);
        check("abort_pre_data", data, 10'd4);
        sys_res_n = 1'b0;
      end
      if (s == 30) begin
        check("abort_fval", fval, 0);
        check("abort_lval", lval, 0);
        check("abort_data", data, 0);
        check("abort_ready", ready, 0);
      end
      if (s == 31) check("abort_cnt_held", frame_cnt, 16'd8);
      if (s == 33) sys_res_n = 1'b1;
      if (s == 48) check("abort_holdoff_15", ready, 0);
      if (s == 49) check("abort_holdoff_16", ready, 1);
    end
    check("abort_no_done", 32'(dones), 0);
    check("abort_cnt", frame_cnt, 16'd8);

    // Counter wrap with pattern 2: data is x + 1023 mod 1024.
    force dut.o_frame_cnt = 16'hFFFF;
    step();
    release dut.o_frame_cnt;
    check("wrap_preload", frame_cnt, 16'hFFFF);
    wrap_rec = '{2'd2, 1, 10'h3FF, 10'h3FF, 10'h006, 16'd0};
    run_frame(wrap_rec);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
